regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port general-purpose register file for the CPU decode/writeback boundary, successor to the fixed 32x32 two-port file. Adds per-byte write enables, byte-merged write-through bypass, a per-register pending-write scoreboard for hazard detection, and a post-reset clear sweep. Read ports feed the decode stage; the write port is driven by writeback.

## Interface
- DW, 32: data width in bits; multiple of 8.
- NREG, 32: register count; power of two, ≥2.
- NRP, 2: number of read ports.
- AW, $clog2(NREG): register address width.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- raddr  in  NRP*AW  read addresses; port i is raddr[i*AW +: AW].
- rdata  out  NRP*DW  read data; port i is rdata[i*DW +: DW].
- rbusy  out  NRP  port i's register has a pending write.
- wen  in  1  write strobe from writeback.
- waddr  in  AW  write address.
- wbytes  in  DW/8  byte-lane enables; bit k covers wdata[8k+7:8k].
- wdata  in  DW  write data.
- sb_set  in  1  issue marks register sb_addr pending.
- sb_addr  in  AW  register to mark pending.
- ready  out  1  clear sweep finished; file usable.
- debug_wb_rf_wen  out  DW/8  effective byte enables committed this cycle.
- debug_wb_rf_wnum  out  AW  equals waddr.
- debug_wb_rf_wdata  out  DW  equals wdata.

## Operation
- States: INIT, RUN. `reset` high forces INIT, sweep counter to 0, all scoreboard bits to 0, and `ready` to 0.
- INIT: each cycle with `reset` low clears rf[cnt] to 0, then increments cnt. When cnt==NREG-1 is cleared, the next state is RUN. wen and sb_set are ignored. All rdata are 0. All rbusy are 0.
- RUN: `ready`=1. Effective write: we = wen & waddr!=0. For every lane k with wbytes[k] set, rf[waddr] byte k takes wdata byte k. Other bytes are preserved.
- Scoreboard: sb_set & sb_addr!=0 sets busy[sb_addr]. we clears busy[waddr] at the edge. If the same register is set and cleared in one cycle, set wins and busy stays 1.
- Read, combinational, per port:
  - raddr==0 gives 0.
  - If we and raddr==waddr, the result is a byte-merge: lane k is wdata byte k if wbytes[k] is set, else the stored byte.
  - Otherwise the stored word.
- rbusy[i] = busy[raddr_i] & ~(we & raddr_i==waddr). A completing write is not reported as busy. Register 0 is never busy.
- Debug outputs: debug_wb_rf_wen = {DW/8{we & ready}} & wbytes. This is 0 for register 0 writes, in INIT, and when wbytes==0. debug_wb_rf_wnum = waddr. debug_wb_rf_wdata = wdata.
- A write with wbytes==0 changes no data but still clears busy.

## Timing
- Reset values: ready=0, busy all 0, rdata all 0, rbusy all 0, debug_wb_rf_wen=0. Storage holds undefined values until the sweep clears it.
- Sweep: with reset sampled low at edges E0..E(NREG-1), one register is cleared per edge. ready=1 after edge E(NREG-1), i.e. NREG cycles after reset deasserts.
- Reset asserted mid-RUN: INIT is entered at that edge. Any write presented in the same cycle is dropped. Busy is cleared and the sweep restarts.
- Reads: zero latency, combinational from raddr, wen, waddr, wbytes, and wdata.
- Writes: visible in storage after the edge, and on bypass in the same cycle.
- Scoreboard: a set is visible on rbusy in the cycle after sb_set.

## Test plan
- Reset sweep, NREG=32:
  - Preload garbage with ready forced high in a prior run.
  - Assert reset for 3 cycles, then release.
  - Expect ready=0 for exactly 32 cycles, then 1.
  - All 32 registers then read 0.
  - Writes issued during the sweep are dropped and debug_wb_rf_wen=0.
- Byte write:
  - Write r5=0xAABBCCDD with wbytes=0xF.
  - Then write wdata=0x11223344 with wbytes=0x5.
  - The read in that same cycle returns the bypass value 0xAA22CC44. The read in the next cycle returns 0xAA22CC44 from storage.
- Register 0:
  - Write r0=0xFFFFFFFF with wbytes=0xF, and sb_set with sb_addr=0.
  - rdata=0, rbusy=0, debug_wb_rf_wen=0.
- Scoreboard:
  - sb_set r7. The next cycle has rbusy=1 on a port reading r7.
  - Write r7 with wbytes=0xF. In that same cycle rbusy=0 and rdata=wdata. Afterwards busy stays 0.
- Simultaneous set and clear:
  - sb_set r9 in the same cycle as a write to r9.
  - The next cycle has rbusy=1 for r9.
- Reset mid-operation with NRP=3:
  - Mark r3 and r4 busy. Assert reset together with a write to r3.
  - After the sweep, busy is all 0 and r3 reads 0 on all three ports.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file for the decode /
// writeback boundary. One byte-maskable write port with same-cycle
// write-through bypass, a per-register pending-write scoreboard, and a
// post-reset sweep that clears every register before the file is usable.
module regfile_mp #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*DW-1:0]   rdata,
    output logic [NRP-1:0]      rbusy,
    input  logic                wen,
    input  logic [AW-1:0]       waddr,
    input  logic [DW/8-1:0]     wbytes,
    input  logic [DW-1:0]       wdata,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic                ready,
    output logic [DW/8-1:0]     debug_wb_rf_wen,
    output logic [AW-1:0]       debug_wb_rf_wnum,
    output logic [DW-1:0]       debug_wb_rf_wdata
);

    localparam int NB = DW / 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [AW-1:0]       cnt;
    logic [NREG-1:0]     busy;
    logic [DW-1:0]       rf [NREG];
    logic                we;
    logic [DW-1:0]       wmask;

    // Lane-wise merge: take new bytes where the mask is set, keep old elsewhere.
    function automatic logic [DW-1:0] byte_merge(
        input logic [DW-1:0] old_word,
        input logic [DW-1:0] new_word,
        input logic [DW-1:0] mask
    );
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    // Expand the per-byte enables into a full-width bit mask.
    always_comb begin
        wmask = '0;
        for (int k = 0; k < NB; k++) begin
            wmask[k*8 +: 8] = {8{wbytes[k]}};
        end
    end

    // Writes only take effect once the sweep has finished; r0 is hard-wired.
    assign we = wen && (waddr != '0) && ready;

    // Sweep / run state machine; ready is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(NREG - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage: sweep clears one entry per cycle, then byte-masked writes.
    // A write coinciding with reset is dropped; contents are not reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                rf[cnt] <= '0;
            end else if (we) begin
                rf[waddr] <= byte_merge(rf[waddr], wdata, wmask);
            end
        end
    end

    // Scoreboard: issue sets, writeback clears; a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else if (state == RUN) begin
            if (we) begin
                busy[waddr] <= 1'b0;
            end
            if (sb_set && (sb_addr != '0)) begin
                busy[sb_addr] <= 1'b1;
            end
        end
    end

    // Read ports: combinational, with write-through bypass of the current write.
    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;

        assign ra  = raddr[i*AW +: AW];
        assign hit = we && (ra == waddr);

        assign rdata[i*DW +: DW] = (!ready || (ra == '0)) ? '0 :
                                   hit ? byte_merge(rf[ra], wdata, wmask) :
                                         rf[ra];
        assign rbusy[i] = ready && busy[ra] && !hit;
    end

    // Commit trace for the writeback debug interface.
    assign debug_wb_rf_wen   = wbytes & {NB{we}};
    assign debug_wb_rf_wnum  = waddr;
    assign debug_wb_rf_wdata = wdata;

endmodule
